// File: rtl/uart_tx_mmio_if.sv
// Store/read bus between the core's data path and the UART peripheral.
// The core drives the store strobe, address and data; the peripheral returns the status read.
interface uart_tx_mmio_if;
  logic        we;
  logic [4:0]  dir;
  logic [7:0]  wd;
  logic        rd_hit;
  logic [31:0] rd_data;

  modport master (output we, dir, wd, input rd_hit, rd_data);
  modport slave  (input we, dir, wd, output rd_hit, rd_data);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding buffer; tx falls one cycle after the store.
// There is no backpressure: a store while the buffer is full is dropped and sets a sticky overflow flag.
module uart_tx_mmio #(
  parameter int         CLK_DIV     = 104,
  parameter logic [4:0] ADDR_DATA   = 5'd28,
  parameter logic [4:0] ADDR_STATUS = 5'd29
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_mmio_if.slave   bus,
  output logic            tx,
  output logic            busy
);

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BTERM = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    hold, hold_n;
  logic          hold_valid, hold_valid_n;
  logic          overflow, overflow_n;
  logic          tx_n;
  logic          load;
  logic          bterm;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bcnt       <= '0;
      bidx       <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      overflow   <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      bcnt       <= bcnt_n;
      bidx       <= bidx_n;
      shift      <= shift_n;
      hold       <= hold_n;
      hold_valid <= hold_valid_n;
      overflow   <= overflow_n;
      tx         <= tx_n;
    end
  end

  always_comb begin
    state_n      = state;
    bcnt_n       = bcnt;
    bidx_n       = bidx;
    shift_n      = shift;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    overflow_n   = overflow;
    tx_n         = tx;
    load         = 1'b0;
    bterm        = (bcnt == BTERM);

    case (state)
      IDLE: load = hold_valid;
      START: begin
        if (bterm) begin
          bcnt_n  = '0;
          bidx_n  = '0;
          tx_n    = shift[0];
          state_n = DATA;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      DATA: begin
        if (bterm) begin
          bcnt_n = '0;
          if (bidx != 3'd7) begin
            shift_n = shift >> 1;
            tx_n    = shift[1];
            bidx_n  = bidx + 3'd1;
          end else begin
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      STOP: begin
        if (bterm) begin
          bcnt_n = '0;
          if (hold_valid) load = 1'b1;
          else            state_n = IDLE;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Loading frees the slot this same edge, so a store arriving now is still accepted.
    if (load) begin
      shift_n      = hold;
      hold_valid_n = 1'b0;
      bcnt_n       = '0;
      tx_n         = 1'b0;
      state_n      = START;
    end

    if (bus.we && bus.dir == ADDR_DATA) begin
      if (!hold_valid || load) begin
        hold_n       = bus.wd;
        hold_valid_n = 1'b1;
      end else begin
        overflow_n = 1'b1;
      end
    end

    if (bus.we && bus.dir == ADDR_STATUS && bus.wd[2]) overflow_n = 1'b0;
  end

  assign busy        = (state != IDLE) || hold_valid;
  assign bus.rd_hit  = (bus.dir == ADDR_STATUS);
  assign bus.rd_data = bus.rd_hit ? {29'b0, overflow, hold_valid, busy} : 32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed scenarios plus random stores, checked every cycle
// against a waveform-level line model and a serial receiver decoding tx.
module tb_uart_tx_mmio;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: queue of line levels still to appear on tx, plus buffer/flag state
  bit         line_q[$];
  bit         m_hv, m_ovf, m_tx, m_busy;
  logic [7:0] m_hold;

  // receiver decoding the DUT's serial output
  logic [7:0] rx_q[$];
  bit         rx_active;
  int         rx_t;
  logic [7:0] rx_byte;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] d, input logic [7:0] v);
    bus.we  = w;
    bus.dir = d;
    bus.wd  = v;
  endtask

  task automatic model_edge();
    bit popped;
    bit lvl;
    if (reset) begin
      line_q.delete();
      m_hv = 0; m_ovf = 0; m_tx = 1; m_busy = 0;
      return;
    end
    if (line_q.size() == 0 && m_hv) begin
      for (int b = 0; b < 10; b++) begin
        lvl = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : m_hold[b-1];
        repeat (CLK_DIV) line_q.push_back(lvl);
      end
      m_hv = 0;
    end
    if (bus.we && bus.dir == 5'd28) begin
      if (!m_hv) begin
        m_hold = bus.wd;
        m_hv   = 1;
      end else begin
        m_ovf = 1;
      end
    end
    if (bus.we && bus.dir == 5'd29 && bus.wd[2]) m_ovf = 0;
    popped = (line_q.size() > 0);
    m_tx   = popped ? line_q.pop_front() : 1'b1;
    m_busy = popped || m_hv;
  endtask

  task automatic rx_sample();
    if (reset) begin
      rx_active = 0;
      return;
    end
    if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1;
        rx_t      = 0;
      end
    end else begin
      rx_t++;
      for (int i = 0; i < 8; i++)
        if (rx_t == CLK_DIV * (i + 1) + CLK_DIV / 2) rx_byte[i] = tx;
      if (rx_t == 9 * CLK_DIV + CLK_DIV / 2) begin
        rx_q.push_back(rx_byte);
        rx_active = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("tx", {31'b0, tx}, {31'b0, m_tx});
    check("busy", {31'b0, busy}, {31'b0, m_busy});
    check("rd_hit", {31'b0, bus.rd_hit}, {31'b0, bus.dir == 5'd29});
    check("rd_data", bus.rd_data, (bus.dir == 5'd29) ? {29'b0, m_ovf, m_hv, m_busy} : 32'd0);
    rx_sample();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 5'd0, 8'h00);
    step();
    step();
    reset = 1'b0;
    rx_q.delete();
  endtask

  int cnt_busy, cnt_low;
  int r;

  initial begin
    reset = 1'b1;
    drive(0, 5'd0, 8'h00);
    do_reset();
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);

    // single byte 0xA5
    drive(1, 5'd28, 8'hA5);
    step();
    cnt_busy = busy;
    cnt_low  = 0;
    drive(0, 5'd0, 8'h00);
    repeat (50) begin
      step();
      cnt_busy += busy;
      cnt_low  += (tx == 1'b0);
    end
    check("a5_busy_len", cnt_busy, 41);
    check("a5_tx_low", cnt_low, 20);
    check("a5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a5_rx_byte", {24'b0, rx_q[0]}, 32'hA5);

    // back-to-back 0x00 then 0xFF
    do_reset();
    drive(1, 5'd28, 8'h00);
    step();
    cnt_busy = busy;
    drive(1, 5'd28, 8'hFF);
    step();
    cnt_busy += busy;
    drive(0, 5'd0, 8'h00);
    repeat (90) begin
      step();
      cnt_busy += busy;
    end
    check("b2b_busy_len", cnt_busy, 81);
    check("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", {24'b0, rx_q[0]}, 32'h00);
      check("b2b_rx1", {24'b0, rx_q[1]}, 32'hFF);
    end

    // overflow and flag clear
    do_reset();
    drive(1, 5'd28, 8'h11); step();
    drive(1, 5'd28, 8'h22); step();
    drive(1, 5'd28, 8'h33); step();
    drive(0, 5'd29, 8'h00); step();
    check("ovf_status", bus.rd_data, 32'h7);
    drive(1, 5'd29, 8'h04); step();
    check("ovf_cleared", bus.rd_data, 32'h3);
    drive(0, 5'd0, 8'h00);
    repeat (90) step();
    check("ovf_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("ovf_rx0", {24'b0, rx_q[0]}, 32'h11);
      check("ovf_rx1", {24'b0, rx_q[1]}, 32'h22);
    end

    // reset mid-frame with a pending byte and a write on the reset edge
    do_reset();
    drive(1, 5'd28, 8'h3C); step();
    drive(1, 5'd28, 8'h5A); step();
    drive(0, 5'd0, 8'h00);
    repeat (15) step();
    reset = 1'b1;
    drive(1, 5'd28, 8'h77);
    step();
    reset = 1'b0;
    check("midrst_tx", {31'b0, tx}, 32'd1);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    drive(0, 5'd0, 8'h00);
    cnt_low = 0;
    repeat (60) begin
      step();
      cnt_low += (tx == 1'b0);
    end
    check("midrst_quiet", cnt_low, 0);
    check("midrst_rx_count", rx_q.size(), 0);

    // address decode
    do_reset();
    drive(1, 5'd27, 8'h55); step();
    drive(0, 5'd0, 8'h00);
    repeat (10) step();
    check("dec_busy", {31'b0, busy}, 32'd0);
    check("dec_tx", {31'b0, tx}, 32'd1);
    drive(0, 5'd29, 8'h00); step();
    check("dec_hit29", {31'b0, bus.rd_hit}, 32'd1);
    drive(0, 5'd28, 8'h00); step();
    check("dec_hit28", {31'b0, bus.rd_hit}, 32'd0);
    check("dec_data28", bus.rd_data, 32'd0);

    // random stores, status reads and occasional resets
    do_reset();
    repeat (4000) begin
      r = $urandom_range(0, 9);
      drive(($urandom_range(0, 5) == 0),
            (r < 4) ? 5'd28 : (r < 7) ? 5'd29 : (r < 8) ? 5'd27 : 5'($urandom),
            8'($urandom));
      reset = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
